// File: rtl/array_multiplier_fa.sv
// One-bit full adder cell used to build the multiplier array.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs always follow the inputs.
//
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module array_multiplier_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/array_multiplier.sv
// Unsigned truncated multiplier: y = (a*b) mod 2^width, built from an AND/full-adder array.
// Latency: 1 cycle (combinational array followed by one output register), full throughput.
// Backpressure: none; a new operand pair is accepted on every rising clk edge.
//
// Ports:
//   clk : clock, rising edge active
//   rst : asynchronous active-high reset, clears y immediately
//   a   : multiplicand, unsigned, width bits
//   b   : multiplier, unsigned, width bits
//   y   : registered low width bits of a*b
module array_multiplier #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] y
);

    // w_sum[i] is the running partial sum after rows 0..i have been added.
    logic [width-1:0] w_sum [width];
    logic [width-1:0] r_y;

    // Row 0 is just the first partial product; no adder needed.
    assign w_sum[0] = a & {width{b[0]}};

    genvar i, k;
    generate
        for (i = 1; i < width; i++) begin : g_row
            // w_c[m] is the carry into bit i+m of this row; the row ripples
            // only across the bits that partial product i can reach.
            logic [width-1-i:0] w_c;

            assign w_c[0] = 1'b0;

            for (k = 0; k < width; k++) begin : g_bit
                if (k < i) begin : g_pass
                    // Below the shift of row i nothing is added.
                    assign w_sum[i][k] = w_sum[i-1][k];
                end else if (k < width - 1) begin : g_fa
                    array_multiplier_fa u_fa (
                        .a    (w_sum[i-1][k]),
                        .b    (a[k-i] & b[i]),
                        .cin  (w_c[k-i]),
                        .s    (w_sum[i][k]),
                        .cout (w_c[k-i+1])
                    );
                end else begin : g_top
                    // Top bit: the carry out would land above the result
                    // width, so only the sum is formed and the carry dropped.
                    assign w_sum[i][k] = w_sum[i-1][k] ^ (a[k-i] & b[i]) ^ w_c[k-i];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= '0;
        end else begin
            r_y <= w_sum[width-1];
        end
    end

    assign y = r_y;

endmodule

// File: tb/tb_array_multiplier.sv
module tb_array_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    array_multiplier #(.width(W)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                         output bit ok);
        n_checks++;
        ok = (act === exp);
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present operands on the falling edge, let one rising edge load them,
    // then sample just after that edge.
    task automatic apply(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] xs;
    function automatic logic [31:0] xorshift(input logic [31:0] x);
        logic [31:0] t;
        t = x;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    initial begin
        bit ok;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rexp;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{32'd3,          32'd5,          32'd15};
        vecs[1] = '{32'd0,          32'hDEADBEEF,   32'd0};
        vecs[2] = '{32'd1,          32'h12345678,   32'h12345678};
        vecs[3] = '{32'h00010000,   32'h00010000,   32'd0};
        vecs[4] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
        vecs[5] = '{32'h80000000,   32'd2,          32'd0};
        vecs[6] = '{32'h12345678,   32'd0,          32'd0};
        vecs[7] = '{32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE};
        vecs[8] = '{32'h0000FFFF,   32'h0000FFFF,   32'hFFFE0001};
        vecs[9] = '{32'd1000,       32'd1000,       32'd1000000};

        // Reset applied at time zero must clear y before any clock edge.
        rst = 1'b1;
        a   = 32'h0000_0007;
        b   = 32'h0000_0009;
        #1;
        check("reset_async_t0", y, 32'd0, ok);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", y, 32'd0, ok);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors.
        for (int n = 0; n < 10; n++) begin
            apply(vecs[n].a, vecs[n].b);
            check($sformatf("vec%0d", n), y, vecs[n].exp, ok);
        end

        // Holding inputs constant keeps y constant.
        repeat (3) @(posedge clk);
        #1;
        check("hold_const", y, 32'd1000000, ok);

        // Back-to-back pairs, one per cycle.
        apply(32'd2, 32'd3);
        check("tput_0", y, 32'd6, ok);
        apply(32'd4, 32'd5);
        check("tput_1", y, 32'd20, ok);
        apply(32'd7, 32'd9);
        check("tput_2", y, 32'd63, ok);

        // Reset between edges with y nonzero clears y without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_mid", y, 32'd0, ok);
        @(posedge clk);
        #1;
        check("reset_hold_edge", y, 32'd0, ok);
        @(negedge clk);
        rst = 1'b0;

        // Random regression with a reset pulse injected partway through.
        xs = 32'd1;
        for (int n = 0; n < 100; n++) begin
            xs   = xorshift(xs);
            ra   = xs;
            xs   = xorshift(xs);
            rb   = xs;
            rexp = ra * rb;
            if (n == 50) begin
                // Pulse reset while the previous product is still on y.
                #1;
                rst = 1'b1;
                #1;
                check("reset_mid_stream", y, 32'd0, ok);
                #1;
                rst = 1'b0;
                if (!ok) break;
            end
            apply(ra, rb);
            check($sformatf("rand%0d", n), y, rexp, ok);
            if (!ok) break;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/array_multiplier.md
Name: array_multiplier

Overview:
Unsigned integer multiplier built as a ripple/carry-save array of AND-gate partial products and full-adder cells. It returns the low `width` bits of a*b, i.e. the product modulo 2^width. The array is combinational and followed by a single output register, giving a fixed 1-cycle latency at full throughput. It is a drop-in arithmetic block for datapaths that need a same-width truncated product.

Parameters:
- width, 32, operand and result width in bits (≥2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  width  multiplicand, unsigned.
- b  input  width  multiplier, unsigned.
- y  output  width  registered product, (a*b) mod 2^width.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: while rst=1, y=0 immediately, without waiting for a clock edge. After rst deasserts, the first rising edge loads a product.
- Datapath:
  - Partial product pp[i][j] = a[j] & b[i].
  - Only terms with i+j < width are generated, forming a triangular array. Higher bits are discarded, not saturated.
  - Row i adds pp[i] shifted by i into the running sum using full-adder cells.
  - Carries out of bit width-1 are dropped.
- Arithmetic: result equals the low width bits of the full 2*width-bit unsigned product. Because the result is truncated, it is also correct for two's-complement operands.
- Timing: on each rising clk edge with rst=0, y <= (a*b) mod 2^width using the a and b values present at that edge.
  - Latency 1 cycle.
  - One new operand pair accepted every cycle.
  - No handshake and no stall.
- No internal state besides y. Holding a and b constant leaves y constant.
- Boundary cases:
  - a=0 or b=0 gives y=0.
  - a=1 gives y=b.
  - Overflow wraps modulo 2^width.
  - All-ones × all-ones gives 1.
- Reset asserted mid-stream: y clears asynchronously. The operand pair sampled in that cycle is lost.
- Must not use the built-in `*` operator. The array must be structural or generate-based. The bench may use `*` as its reference model.

Decomposition:
- No shared package is needed. The width parameter is the only configuration.
- One natural sub-module: `array_multiplier_fa`, a 1-bit full adder (a, b, cin -> s, cout).
  - The top module instantiates a generate grid of these cells.
  - The top module also contains the AND-gate partial products and the output register.

Test Plan:
- Reset: assert rst with y previously nonzero -> y=0 before the next clk edge; stays 0 while rst=1.
- Directed small values: a=3, b=5 -> y=15 one cycle later; a=0, b=0xDEADBEEF -> y=0; a=1, b=0x12345678 -> y=0x12345678.
- Overflow: a=0x00010000, b=0x00010000 -> y=0; a=b=0xFFFFFFFF -> y=0x00000001; a=0x80000000, b=2 -> y=0.
- Throughput: apply a new pair every cycle (2*3, 4*5, 7*9) -> y sequence 6, 20, 63 on consecutive cycles, each 1 cycle after its inputs.
- Random regression:
  - Generate 100 vectors with xorshift32 (seed 1, shifts 13/17/5).
  - Apply a then b, each from successive generator outputs.
  - Check y == (a*b) mod 2^32 one cycle later; stop on the first mismatch.
- Mid-stream reset: pulse rst between clock edges during the random stream -> y=0 immediately; the first edge after release yields the correct product of the current inputs.
